// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - mode encoding shared by the universal shift register files
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/usr_frame_cnt.sv
// rtl/usr_frame_cnt.sv - modulo-WIDTH shift counter with registered frame_done pulse
module usr_frame_cnt
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic wrap;

    // A frame completes on the increment that takes the count past WIDTH-1.
    assign wrap = inc && (shift_cnt == LAST);

    // Count shifts; frame_done follows the wrapping edge by exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap && !clr;
            if (clr) begin
                shift_cnt <= '0;
            end else if (inc) begin
                shift_cnt <= wrap ? '0 : shift_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal shift register (hold/shr/shl/load), USR_ROTATE_EN adds rot input
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             s_in_r,
    input  logic             s_in_l,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] p_out,
    output logic             s_out_r,
    output logic             s_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    mode_t      mode_e;
    logic       fill_r;
    logic       fill_l;
    logic       cnt_inc;
    logic       cnt_clr;
    logic [WIDTH-1:0] data;

    assign mode_e = mode_t'(mode);

`ifdef USR_ROTATE_EN
    // Rotation recirculates the bit falling off the opposite end.
    assign fill_r = rot ? data[0]       : s_in_r;
    assign fill_l = rot ? data[WIDTH-1] : s_in_l;
`else
    assign fill_r = s_in_r;
    assign fill_l = s_in_l;
`endif

    // Datapath register: shift or load only on enabled edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (en) begin
            case (mode_e)
                MODE_SHR:  data <= {fill_r, data[WIDTH-1:1]};
                MODE_SHL:  data <= {data[WIDTH-2:0], fill_l};
                MODE_LOAD: data <= p_in;
                default:   data <= data;
            endcase
        end
    end

    assign cnt_inc = en && ((mode_e == MODE_SHR) || (mode_e == MODE_SHL));
    assign cnt_clr = en && (mode_e == MODE_LOAD);

    usr_frame_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr        (cnt_clr),
        .inc        (cnt_inc),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    assign p_out   = data;
    assign s_out_r = data[0];
    assign s_out_l = data[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg
module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct {
        logic          en;
        logic [1:0]    mode;
        logic          sr;
        logic          sl;
        logic [W-1:0]  pin;
        logic [W-1:0]  p;
        logic [CW-1:0] cnt;
        logic          fd;
    } vec_t;

    typedef struct {
        logic [W-1:0]  p;
        logic [CW-1:0] cnt;
        logic          fd;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          en;
    logic [1:0]    mode;
    logic          s_in_r;
    logic          s_in_l;
    logic          rot_v;
    logic [W-1:0]  p_in;
    logic [W-1:0]  p_out;
    logic          s_out_r;
    logic          s_out_l;
    logic [CW-1:0] shift_cnt;
    logic          frame_done;

    int   checks;
    int   errors;
    vec_t tbl[$];
    exp_t exp_q[$];

    logic [W-1:0]  m_p;
    logic [CW-1:0] m_cnt;
    logic          m_fd;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .s_in_r     (s_in_r),
        .s_in_l     (s_in_l),
`ifdef USR_ROTATE_EN
        .rot        (rot_v),
`endif
        .p_in       (p_in),
        .p_out      (p_out),
        .s_out_r    (s_out_r),
        .s_out_l    (s_out_l),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                       input logic [W-1:0] pin, input logic [W-1:0] p,
                       input logic [CW-1:0] c, input logic fd);
        vec_t v;
        v.en = e; v.mode = m; v.sr = sr; v.sl = sl; v.pin = pin;
        v.p = p; v.cnt = c; v.fd = fd;
        tbl.push_back(v);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({name, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_p_out"},      p_out,      e.p);
            chk({name, "_shift_cnt"},  shift_cnt,  e.cnt);
            chk({name, "_frame_done"}, frame_done, e.fd);
            chk({name, "_s_out_r"},    s_out_r,    e.p[0]);
            chk({name, "_s_out_l"},    s_out_l,    e.p[W-1]);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        en = v.en; mode = v.mode; s_in_r = v.sr; s_in_l = v.sl; p_in = v.pin;
        e.p = v.p; e.cnt = v.cnt; e.fd = v.fd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    task automatic mstep(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                         input logic [W-1:0] pin, input string name);
        vec_t v;
        logic wrap;
        wrap = 1'b0;
        if (e) begin
            case (m)
                2'b01: begin
                    m_p  = {(rot_v ? m_p[0] : sr), m_p[W-1:1]};
                    wrap = (m_cnt == CW'(W - 1));
                    m_cnt = wrap ? '0 : m_cnt + 1'b1;
                end
                2'b10: begin
                    m_p  = {m_p[W-2:0], (rot_v ? m_p[W-1] : sl)};
                    wrap = (m_cnt == CW'(W - 1));
                    m_cnt = wrap ? '0 : m_cnt + 1'b1;
                end
                2'b11: begin
                    m_p   = pin;
                    m_cnt = '0;
                end
                default: ;
            endcase
        end
        m_fd = wrap;
        v.en = e; v.mode = m; v.sr = sr; v.sl = sl; v.pin = pin;
        v.p = m_p; v.cnt = m_cnt; v.fd = m_fd;
        apply(v, name);
    endtask

    task automatic do_reset(input string name);
        #2 reset = 1'b1;
        #1;
        chk({name, "_async_p_out"},      p_out,      64'd0);
        chk({name, "_async_shift_cnt"},  shift_cnt,  64'd0);
        chk({name, "_async_frame_done"}, frame_done, 64'd0);
        #1 reset = 1'b0;
        m_p = '0; m_cnt = '0; m_fd = 1'b0;
    endtask

    initial begin
        int first_hi;
        int fd_count;
        vec_t v;
        checks = 0; errors = 0;
        reset = 1'b0; en = 1'b0; mode = 2'b00; s_in_r = 1'b0; s_in_l = 1'b0;
        p_in = '0; rot_v = 1'b0;
        m_p = '0; m_cnt = '0; m_fd = 1'b0;

        // SIPO frame: 1,0,1,1,0,0,1,0 into the MSB
        add(1, 2'b01, 1, 0, 8'h00, 8'h80, 4'd1, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h40, 4'd2, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hA0, 4'd3, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hD0, 4'd4, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h68, 4'd5, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h34, 4'd6, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'h9A, 4'd7, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h4D, 4'd0, 1);
        add(1, 2'b00, 1, 1, 8'h00, 8'h4D, 4'd0, 0);
        // PISO drain of A5 out of the MSB
        add(1, 2'b11, 0, 0, 8'hA5, 8'hA5, 4'd0, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h4A, 4'd1, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h94, 4'd2, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h28, 4'd3, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h50, 4'd4, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'hA0, 4'd5, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h40, 4'd6, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h80, 4'd7, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h00, 4'd0, 1);
        add(1, 2'b00, 0, 0, 8'h00, 8'h00, 4'd0, 0);
        // Hold via en=0 and via mode 00
        add(1, 2'b11, 0, 0, 8'h3C, 8'h3C, 4'd0, 0);
        for (int i = 0; i < 4; i++) add(0, 2'b01, 1, 1, 8'h00, 8'h3C, 4'd0, 0);
        for (int i = 0; i < 4; i++) add(1, 2'b00, 1, 1, 8'hFF, 8'h3C, 4'd0, 0);
        // Load mid-frame, then direction change without clearing the count
        add(1, 2'b01, 0, 0, 8'h00, 8'h1E, 4'd1, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h0F, 4'd2, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h07, 4'd3, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h03, 4'd4, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h01, 4'd5, 0);
        add(1, 2'b11, 0, 0, 8'hFF, 8'hFF, 4'd0, 0);
        add(1, 2'b10, 0, 1, 8'h00, 8'hFF, 4'd1, 0);
        add(1, 2'b10, 0, 1, 8'h00, 8'hFF, 4'd2, 0);
        add(1, 2'b10, 0, 1, 8'h00, 8'hFF, 4'd3, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h7F, 4'd4, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h3F, 4'd5, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h1F, 4'd6, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h0F, 4'd7, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h07, 4'd0, 1);

        // Reset state, and inputs ignored while reset is high
        #2 reset = 1'b1;
        #1;
        chk("reset_p_out",      p_out,      64'd0);
        chk("reset_shift_cnt",  shift_cnt,  64'd0);
        chk("reset_frame_done", frame_done, 64'd0);
        en = 1'b1; mode = 2'b11; p_in = 8'hFF;
        @(posedge clk);
        #1;
        chk("reset_ignores_load", p_out, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            apply(v, $sformatf("vec%0d", i));
        end

        // SISO delay: a single 1 reaches s_out_r after WIDTH shifts
        do_reset("siso");
        first_hi = 0;
        for (int k = 1; k <= 16; k++) begin
            mstep(1, 2'b01, (k == 1), 0, 8'h00, $sformatf("siso%0d", k));
            if (first_hi == 0 && s_out_r === 1'b1) first_hi = k;
        end
        chk("siso_delay_edges", first_hi, 64'd8);

        // Reset mid-frame aborts it; the next full frame pulses once
        do_reset("pre_mid");
        for (int k = 0; k < 3; k++) mstep(1, 2'b01, 1, 0, 8'h00, $sformatf("mid%0d", k));
        chk("mid_cnt_before_reset", shift_cnt, 64'd3);
        do_reset("mid");
        fd_count = 0;
        for (int k = 0; k < 9; k++) begin
            mstep(1, 2'b01, k[0], 0, 8'h00, $sformatf("post%0d", k));
            if (frame_done === 1'b1) fd_count++;
        end
        chk("post_reset_frame_pulses", fd_count, 64'd1);

`ifdef USR_ROTATE_EN
        // Rotation: 8 right rotates of 81 return to 81
        mstep(1, 2'b11, 0, 0, 8'h81, "rot_load");
        rot_v = 1'b1;
        for (int k = 0; k < 8; k++) mstep(1, 2'b01, 0, 0, 8'h00, $sformatf("rot%0d", k));
        chk("rot_final_p_out", p_out, 64'h81);
        chk("rot_frame_done", frame_done, 64'd1);
        rot_v = 1'b0;
`endif

        chk("queue_drained", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
